// File: rtl/ext_sram_bridge.sv
// Purpose : bridges a 32-bit CPU memory request onto an 8-bit async SRAM, one byte per SETUP/STROBE/HOLD cycle.
// Latency : 4*(2+WAIT_CYCLES) edges from acceptance to DONE; req_ready is a one-cycle pulse in DONE.
// Backpr. : busy is high for the whole access; requests are only sampled in IDLE, all others ignored.
//
// Ports:
//   clk, rst_n                 clock, asynchronous active-low reset
//   req_addr/req_wdata         CPU byte address and write data (latched at acceptance)
//   req_read/req_write         request strobes, gated by req_enable; write wins if both are set
//   req_rdata, req_ready, busy assembled read word, completion pulse, access in progress
//   sram_*                     registered SRAM address, data, drive enable and active-low controls
module ext_sram_bridge #(
    parameter int ADDR_W      = 20,
    parameter int WAIT_CYCLES = 2
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [31:0]       req_addr,
    input  logic [31:0]       req_wdata,
    input  logic              req_read,
    input  logic              req_write,
    input  logic              req_enable,
    output logic [31:0]       req_rdata,
    output logic              req_ready,
    output logic              busy,
    output logic [ADDR_W-1:0] sram_addr,
    output logic [7:0]        sram_dq_out,
    input  logic [7:0]        sram_dq_in,
    output logic              sram_dq_oe,
    output logic              sram_ce_n,
    output logic              sram_oe_n,
    output logic              sram_we_n
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_SETUP,
        S_STROBE,
        S_HOLD,
        S_DONE
    } state_t;

    // wait_cnt is loaded with WAIT_CYCLES-1 and counts down to zero, giving WAIT_CYCLES strobe cycles.
    localparam logic [3:0] STROBE_LAST = 4'(WAIT_CYCLES - 1);

    state_t              state, state_nxt;
    logic [1:0]          byte_idx, byte_nxt;
    logic [3:0]          wait_cnt, wait_nxt;
    logic [ADDR_W-3:0]   word_addr, addr_nxt;
    logic [31:0]         wdata_q, wdata_nxt;
    logic                is_wr, wr_nxt;
    logic [31:0]         shadow, shadow_nxt;
    logic [31:0]         rdata_nxt;
    logic                active_nxt;

    // Byte offset and address bits above the SRAM range alias onto the same word.
    logic unused_addr_bits;
    assign unused_addr_bits = ^{req_addr[31:ADDR_W], req_addr[1:0]};

    always_comb begin
        state_nxt  = state;
        byte_nxt   = byte_idx;
        wait_nxt   = wait_cnt;
        addr_nxt   = word_addr;
        wdata_nxt  = wdata_q;
        wr_nxt     = is_wr;
        shadow_nxt = shadow;
        rdata_nxt  = req_rdata;
        case (state)
            S_IDLE: begin
                if (req_enable && (req_read || req_write)) begin
                    addr_nxt  = req_addr[ADDR_W-1:2];
                    wdata_nxt = req_wdata;
                    wr_nxt    = req_write;
                    byte_nxt  = 2'd0;
                    state_nxt = S_SETUP;
                end
            end
            S_SETUP: begin
                wait_nxt  = STROBE_LAST;
                state_nxt = S_STROBE;
            end
            S_STROBE: begin
                if (wait_cnt == 4'd0) begin
                    state_nxt = S_HOLD;
                    // Sample the SRAM at the end of the last oe_n-low cycle.
                    if (!is_wr) begin
                        shadow_nxt[{byte_idx, 3'b000} +: 8] = sram_dq_in;
                    end
                end else begin
                    wait_nxt = wait_cnt - 4'd1;
                end
            end
            S_HOLD: begin
                if (byte_idx == 2'd3) begin
                    state_nxt = S_DONE;
                    if (!is_wr) begin
                        rdata_nxt = shadow;
                    end
                end else begin
                    byte_nxt  = byte_idx + 2'd1;
                    state_nxt = S_SETUP;
                end
            end
            S_DONE: begin
                state_nxt = S_IDLE;
            end
            default: begin
                state_nxt = S_IDLE;
            end
        endcase
    end

    assign active_nxt = (state_nxt == S_SETUP) || (state_nxt == S_STROBE) || (state_nxt == S_HOLD);

    // Every output is registered from the next-state values, so pins change exactly on state entry
    // and no request input reaches an SRAM pin combinationally.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= S_IDLE;
            byte_idx    <= 2'd0;
            wait_cnt    <= 4'd0;
            word_addr   <= '0;
            wdata_q     <= 32'd0;
            is_wr       <= 1'b0;
            shadow      <= 32'd0;
            req_rdata   <= 32'd0;
            req_ready   <= 1'b0;
            busy        <= 1'b0;
            sram_addr   <= '0;
            sram_dq_out <= 8'd0;
            sram_dq_oe  <= 1'b0;
            sram_ce_n   <= 1'b1;
            sram_oe_n   <= 1'b1;
            sram_we_n   <= 1'b1;
        end else begin
            state       <= state_nxt;
            byte_idx    <= byte_nxt;
            wait_cnt    <= wait_nxt;
            word_addr   <= addr_nxt;
            wdata_q     <= wdata_nxt;
            is_wr       <= wr_nxt;
            shadow      <= shadow_nxt;
            req_rdata   <= rdata_nxt;
            req_ready   <= (state_nxt == S_DONE);
            busy        <= (state_nxt != S_IDLE);
            sram_ce_n   <= !active_nxt;
            sram_oe_n   <= !((state_nxt == S_STROBE) && !wr_nxt);
            sram_we_n   <= !((state_nxt == S_STROBE) && wr_nxt);
            sram_dq_oe  <= active_nxt && wr_nxt;
            // Address and data stay put through HOLD so we_n rises a full cycle before they move.
            if (active_nxt) begin
                sram_addr   <= {addr_nxt, byte_nxt};
                sram_dq_out <= wdata_nxt[{byte_nxt, 3'b000} +: 8];
            end
        end
    end

endmodule

// File: tb/tb_ext_sram_bridge.sv
`timescale 1ns/1ps
module tb_ext_sram_bridge;

    logic        clk = 1'b0;
    logic        rst_n;
    always #5 clk = ~clk;

    // Main instance, WAIT_CYCLES = 2, backed by a small byte-array SRAM model.
    logic [31:0] req_addr, req_wdata, req_rdata;
    logic        req_read, req_write, req_enable, req_ready, busy;
    logic [19:0] sram_addr;
    logic [7:0]  sram_dq_out, sram_dq_in;
    logic        sram_dq_oe, sram_ce_n, sram_oe_n, sram_we_n;

    // Two extra instances (WAIT_CYCLES 1 and 4) share one request bus and read constant bytes.
    logic [31:0] aux_addr, aux_wdata;
    logic        aux_rd, aux_wr, aux_en;
    logic [31:0] a1_rdata, a4_rdata;
    logic        a1_ready, a4_ready, a1_busy, a4_busy;
    logic [19:0] a1_addr, a4_addr;
    logic [7:0]  a1_dq_out, a4_dq_out, a1_dq_in, a4_dq_in;
    logic        a1_dq_oe, a4_dq_oe, a1_ce_n, a4_ce_n, a1_oe_n, a4_oe_n, a1_we_n, a4_we_n;

    assign a1_dq_in = 8'h5A;
    assign a4_dq_in = 8'hA5;

    logic [7:0] mem [0:255];
    assign sram_dq_in = (!sram_ce_n && !sram_oe_n) ? mem[sram_addr[7:0]] : 8'h00;
    always @(posedge clk) begin
        if (rst_n && !sram_ce_n && !sram_we_n && sram_dq_oe) mem[sram_addr[7:0]] <= sram_dq_out;
    end

    ext_sram_bridge #(.ADDR_W(20), .WAIT_CYCLES(2)) dut (
        .clk(clk), .rst_n(rst_n), .req_addr(req_addr), .req_wdata(req_wdata),
        .req_read(req_read), .req_write(req_write), .req_enable(req_enable),
        .req_rdata(req_rdata), .req_ready(req_ready), .busy(busy),
        .sram_addr(sram_addr), .sram_dq_out(sram_dq_out), .sram_dq_in(sram_dq_in),
        .sram_dq_oe(sram_dq_oe), .sram_ce_n(sram_ce_n), .sram_oe_n(sram_oe_n), .sram_we_n(sram_we_n)
    );

    ext_sram_bridge #(.ADDR_W(20), .WAIT_CYCLES(1)) dut_w1 (
        .clk(clk), .rst_n(rst_n), .req_addr(aux_addr), .req_wdata(aux_wdata),
        .req_read(aux_rd), .req_write(aux_wr), .req_enable(aux_en),
        .req_rdata(a1_rdata), .req_ready(a1_ready), .busy(a1_busy),
        .sram_addr(a1_addr), .sram_dq_out(a1_dq_out), .sram_dq_in(a1_dq_in),
        .sram_dq_oe(a1_dq_oe), .sram_ce_n(a1_ce_n), .sram_oe_n(a1_oe_n), .sram_we_n(a1_we_n)
    );

    ext_sram_bridge #(.ADDR_W(20), .WAIT_CYCLES(4)) dut_w4 (
        .clk(clk), .rst_n(rst_n), .req_addr(aux_addr), .req_wdata(aux_wdata),
        .req_read(aux_rd), .req_write(aux_wr), .req_enable(aux_en),
        .req_rdata(a4_rdata), .req_ready(a4_ready), .busy(a4_busy),
        .sram_addr(a4_addr), .sram_dq_out(a4_dq_out), .sram_dq_in(a4_dq_in),
        .sram_dq_oe(a4_dq_oe), .sram_ce_n(a4_ce_n), .sram_oe_n(a4_oe_n), .sram_we_n(a4_we_n)
    );

    typedef struct {
        logic        wr;
        logic [31:0] rdata;
        int          acc;
        logic [19:0] base;
    } exp_t;

    exp_t        sb[$];
    logic [19:0] strb_addr[$];
    int          vectors = 0;
    int          errors = 0;
    int          cyc = 0;
    int          run = 0;
    logic        rd_oe_seen = 1'b0;
    logic [31:0] last_rd = 32'd0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Monitor: tracks strobe runs and addresses, and checks each completion against the scoreboard.
    // Latency counts the acceptance edge through the edge at which the CPU samples req_ready.
    always @(negedge clk) begin
        if (!rst_n) begin
            run = 0;
        end else begin
            if (!sram_oe_n || !sram_we_n) begin
                if (run == 0) strb_addr.push_back(sram_addr);
                run++;
            end else if (run != 0) begin
                chk("strobe_width", run, 2);
                run = 0;
            end
            if (sb.size() > 0 && !sb[0].wr && sram_dq_oe) rd_oe_seen = 1'b1;
            if (req_ready) begin
                if (sb.size() == 0) begin
                    vectors++;
                    errors++;
                    $display("FAIL spurious_ready: got req_ready=1 expected no pending access");
                end else begin
                    exp_t e;
                    e = sb.pop_front();
                    chk("latency", cyc - e.acc + 1, 17);
                    chk(e.wr ? "rdata_after_write" : "rdata", req_rdata, e.rdata);
                    chk("n_strobes", strb_addr.size(), 4);
                    for (int i = 0; i < 4; i++) begin
                        if (i < strb_addr.size()) chk("byte_addr", {12'd0, strb_addr[i]}, {12'd0, e.base + 20'(i)});
                    end
                    if (!e.wr) chk("rd_dq_oe", rd_oe_seen, 0);
                end
                strb_addr.delete();
                rd_oe_seen = 1'b0;
            end
        end
    end

    // d is the write data for writes, or the hand-computed read word for reads.
    task automatic issue(input logic rd, input logic wr, input logic [31:0] addr, input logic [31:0] d,
                         input int hold, input bit keep);
        exp_t e;
        int   k;
        k = 0;
        @(negedge clk);
        while (busy && k < 100) begin
            @(negedge clk);
            k++;
        end
        if (busy) begin
            vectors++;
            errors++;
            $display("FAIL idle_wait: got busy=1 expected idle within 100 cycles");
        end
        req_addr = addr; req_wdata = d; req_read = rd; req_write = wr; req_enable = 1'b1;
        @(negedge clk);
        chk("accept_busy", busy, 1);
        e.wr    = wr;
        e.rdata = wr ? last_rd : d;
        if (!wr) last_rd = d;
        e.acc   = cyc;
        e.base  = {addr[19:2], 2'b00};
        sb.push_back(e);
        for (int i = 0; i < hold; i++) @(negedge clk);
        if (!keep) begin
            req_read = 1'b0; req_write = 1'b0; req_enable = 1'b0;
        end
    endtask

    task automatic wait_done();
        int k;
        k = 0;
        while (sb.size() != 0 && k < 100) begin
            @(negedge clk);
            k++;
        end
        if (sb.size() != 0) begin
            vectors++;
            errors++;
            $display("FAIL completion_timeout: got %0d pending expected 0", sb.size());
            sb.delete();
        end
        @(negedge clk);
    endtask

    task automatic aux_run(input logic wr);
        int run1, run4, n1, n4, lat1, lat4, a0;
        run1 = 0; run4 = 0; n1 = 0; n4 = 0; lat1 = 0; lat4 = 0;
        @(negedge clk);
        aux_addr = 32'h0000_0104; aux_wdata = 32'h0102_0304; aux_rd = !wr; aux_wr = wr; aux_en = 1'b1;
        @(negedge clk);
        aux_rd = 1'b0; aux_wr = 1'b0; aux_en = 1'b0;
        a0 = cyc;
        for (int k = 0; k < 40; k++) begin
            if (!(wr ? a1_we_n : a1_oe_n)) run1++;
            else if (run1 != 0) begin chk("w1_strobe_low", run1, 1); n1++; run1 = 0; end
            if (!(wr ? a4_we_n : a4_oe_n)) run4++;
            else if (run4 != 0) begin chk("w4_strobe_low", run4, 4); n4++; run4 = 0; end
            if (a1_ready && lat1 == 0) lat1 = cyc - a0 + 1;
            if (a4_ready && lat4 == 0) lat4 = cyc - a0 + 1;
            @(negedge clk);
        end
        chk("w1_latency", lat1, 13);
        chk("w4_latency", lat4, 25);
        chk("w1_bytes", n1, 4);
        chk("w4_bytes", n4, 4);
        if (!wr) begin
            chk("w1_rdata", a1_rdata, 32'h5A5A_5A5A);
            chk("w4_rdata", a4_rdata, 32'hA5A5_A5A5);
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got no finish expected finish before 200us");
        $fatal(1);
    end

    initial begin
        int k;
        req_addr = 0; req_wdata = 0; req_read = 0; req_write = 0; req_enable = 0;
        aux_addr = 0; aux_wdata = 0; aux_rd = 0; aux_wr = 0; aux_en = 0;
        rst_n = 1'b1;
        #1 rst_n = 1'b0;
        #2;
        chk("rst_ce_n", sram_ce_n, 1);
        chk("rst_oe_n", sram_oe_n, 1);
        chk("rst_we_n", sram_we_n, 1);
        chk("rst_dq_oe", sram_dq_oe, 0);
        chk("rst_addr", {12'd0, sram_addr}, 0);
        chk("rst_dq_out", sram_dq_out, 0);
        chk("rst_rdata", req_rdata, 0);
        chk("rst_ready", req_ready, 0);
        chk("rst_busy", busy, 0);
        @(posedge clk); @(posedge clk); #2 rst_n = 1'b1;

        // Write then read back, little-endian byte placement.
        issue(0, 1, 32'h0010_0010, 32'hDEAD_BEEF, 0, 0);
        wait_done();
        chk("mem_10", mem[8'h10], 8'hEF);
        chk("mem_11", mem[8'h11], 8'hBE);
        chk("mem_12", mem[8'h12], 8'hAD);
        chk("mem_13", mem[8'h13], 8'hDE);
        issue(1, 0, 32'h0010_0010, 32'hDEAD_BEEF, 0, 0);
        wait_done();

        // Byte offset and high-address aliasing.
        issue(1, 0, 32'h0010_0012, 32'hDEAD_BEEF, 0, 0);
        issue(1, 0, 32'h8010_0010, 32'hDEAD_BEEF, 0, 0);
        wait_done();

        // Read and write together performs a write and leaves req_rdata alone.
        issue(1, 1, 32'h0000_0020, 32'h1122_3344, 0, 0);
        wait_done();
        chk("mem_20", mem[8'h20], 8'h44);
        chk("mem_21", mem[8'h21], 8'h33);
        chk("mem_22", mem[8'h22], 8'h22);
        chk("mem_23", mem[8'h23], 8'h11);

        // Request dropped 3 cycles into the access still completes once.
        issue(1, 0, 32'h0000_0020, 32'h1122_3344, 3, 0);
        wait_done();

        // Request held past req_ready starts a second access after the IDLE cycle.
        issue(1, 0, 32'h0010_0010, 32'hDEAD_BEEF, 17, 1);
        chk("held_idle_gap", busy, 0);
        @(negedge clk);
        chk("held_reaccept", busy, 1);
        sb.push_back('{wr: 1'b0, rdata: 32'hDEAD_BEEF, acc: cyc, base: 20'h00010});
        req_read = 1'b0; req_enable = 1'b0;
        wait_done();

        // Disabled region: no activity at all.
        req_addr = 32'h0000_0010; req_read = 1'b1; req_enable = 1'b0;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            chk("dis_ce_n", sram_ce_n, 1);
            chk("dis_busy", busy, 0);
            chk("dis_ready", req_ready, 0);
        end
        req_read = 1'b0;

        // Reset in the middle of byte 2's write strobe.
        issue(0, 1, 32'h0000_0040, 32'hCAFE_F00D, 0, 0);
        k = 0;
        while (!(sram_addr[1:0] == 2'd2 && !sram_we_n) && k < 60) begin
            @(negedge clk);
            k++;
        end
        chk("rst_at_byte2", {12'd0, sram_addr}, 32'h42);
        #2 rst_n = 1'b0;
        #1;
        chk("mid_rst_we_n", sram_we_n, 1);
        chk("mid_rst_ce_n", sram_ce_n, 1);
        chk("mid_rst_oe_n", sram_oe_n, 1);
        chk("mid_rst_dq_oe", sram_dq_oe, 0);
        chk("mid_rst_rdata", req_rdata, 0);
        chk("mid_rst_busy", busy, 0);
        sb.delete();
        strb_addr.delete();
        last_rd = 32'd0;
        rd_oe_seen = 1'b0;
        @(posedge clk); @(posedge clk); #2 rst_n = 1'b1;
        issue(1, 0, 32'h0000_0020, 32'h1122_3344, 0, 0);
        wait_done();

        // Strobe width and latency for WAIT_CYCLES 1 and 4.
        aux_run(1'b0);
        aux_run(1'b1);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
        $finish;
    end

endmodule
